// File: rtl/mas_alu_right_shift_seq.sv
// Multi-cycle right shifter for the MAS ALU. It computes op1 >> op2, either
// logical or arithmetic. The datapath is log-step iterative: each cycle
// applies one power-of-two stage, so only a single stage of shift muxing is
// built. There is a valid/ready handshake on both the operand side and the
// result side.
module mas_alu_right_shift_seq #(
  parameter int BLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BLEN-1:0] op1,
  input  logic [BLEN-1:0] op2,
  input  logic            arith,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BLEN-1:0] res
);

  localparam int SHW = $clog2(BLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(SHW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [BLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  amt_q, amt_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            fill_q, fill_d;
  logic [BLEN-1:0] res_q, res_d;
  logic [BLEN-1:0] work_stage;
  logic            over_range;
  logic            fill_in;

  // One shift stage: shift right by 2**c, back-filling the vacated MSBs with f.
  function automatic logic [BLEN-1:0] stage_shift(input logic [BLEN-1:0] w,
                                                  input logic [SHW-1:0]  c,
                                                  input logic            f);
    logic [2*BLEN-1:0] ext;
    ext = {{BLEN{f}}, w} >> (1 << c);
    return ext[BLEN-1:0];
  endfunction

  assign over_range = |op2[BLEN-1:SHW];
  assign fill_in    = arith & op1[BLEN-1];
  assign work_stage = amt_q[cnt_q] ? stage_shift(work_q, cnt_q, fill_q) : work_q;

  assign in_ready   = (state_q == IDLE) & ~rst;
  assign out_valid  = (state_q == DONE);
  assign res        = res_q;

  // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          fill_d  = fill_in;
          state_d = SHIFT;
          if (over_range) begin
            // Over-range shortcut: preload the all-fill word and jump straight
            // to the last stage with no stage enabled. The result then lands
            // exactly one cycle after accept, and res is only updated at
            // completion.
            work_d = {BLEN{fill_in}};
            amt_d  = '0;
            cnt_d  = CNT_LAST;
          end else begin
            work_d = op1;
            amt_d  = op2[SHW-1:0];
            cnt_d  = '0;
          end
        end
      end
      SHIFT: begin
        work_d = work_stage;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = work_stage;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mas_alu_right_shift_seq.sv
// Testbench for mas_alu_right_shift_seq (BLEN=32). It applies a table of
// vectors, then random operations checked against the shift operators, then
// hand-written back-pressure and mid-operation reset sequences. Expected
// results are held on a queue until the DUT presents them.
module tb_mas_alu_right_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  mas_alu_right_shift_seq #(.BLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .arith(arith), .out_valid(out_valid),
    .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        arith;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vt[11];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one operation for one edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic ar,
                        input logic [31:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op1 = a; op2 = b; arith = ar;
    tick();
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; arith = 1'($urandom);
    exp_q.push_back(e);
  endtask

  // Count cycles to out_valid (bounded), check latency and result, then transfer it.
  task automatic collect(input string name, input int lat);
    int n;
    logic [31:0] e;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({name, "_latency"}, n, lat);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 32'hDEAD_BEEF;
    chk({name, "_res"}, res, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_res_held"}, res, e);
  endtask

  initial begin
    logic [31:0] a, b, e, held;
    logic        ar;

    vt[0]  = '{32'h8000_00F0, 32'd4,     1'b0, 32'h0800_000F, 5};
    vt[1]  = '{32'h8000_00F0, 32'd4,     1'b1, 32'hF800_000F, 5};
    vt[2]  = '{32'h8000_0000, 32'd40,    1'b1, 32'hFFFF_FFFF, 1};
    vt[3]  = '{32'h8000_0000, 32'd40,    1'b0, 32'h0000_0000, 1};
    vt[4]  = '{32'h1234_5678, 32'd0,     1'b0, 32'h1234_5678, 5};
    vt[5]  = '{32'hFFFF_FFFF, 32'd31,    1'b0, 32'h0000_0001, 5};
    vt[6]  = '{32'hFFFF_FFFF, 32'd32,    1'b0, 32'h0000_0000, 1};
    vt[7]  = '{32'h8000_0000, 32'd31,    1'b1, 32'hFFFF_FFFF, 5};
    vt[8]  = '{32'hF0F0_0000, 32'd12,    1'b1, 32'hFFFF_0F00, 5};
    vt[9]  = '{32'h7000_0000, 32'h100,   1'b1, 32'h0000_0000, 1};
    vt[10] = '{32'h8765_4321, 32'd0,     1'b1, 32'h8765_4321, 5};

    rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; arith = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_in_ready_during_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      accept(vt[i].op1, vt[i].op2, vt[i].arith, vt[i].exp);
      collect($sformatf("vec%0d", i), vt[i].lat);
    end

    for (int i = 0; i < 12; i++) begin
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(32, 100)) : 32'($urandom_range(0, 31));
      ar = 1'($urandom);
      e  = ar ? 32'($signed(a) >>> b) : (a >> b);
      accept(a, b, ar, e);
      collect($sformatf("rand%0d", i), (b >= 32) ? 1 : 5);
    end

    // Back-pressure: hold out_ready low for 3 cycles and offer a new operation meanwhile.
    accept(32'hA5A5_0000, 32'd8, 1'b1, 32'hFFA5_A500);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    held = res;
    chk("bp_res_value", held, 32'hFFA5_A500);
    in_valid = 1'b1; op1 = 32'h0000_FFFF; op2 = 32'd1; arith = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid_stable", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_res_stable", res, held);
      tick();
    end
    in_valid = 1'b0;
    collect("bp", 0);
    accept(32'h0000_FFFF, 32'd1, 1'b0, 32'h0000_7FFF);
    collect("bp_next", 5);

    // Reset two cycles after accept discards the operation.
    accept(32'hC000_0000, 32'd3, 1'b1, 32'h0);
    void'(exp_q.pop_back());
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready_during_rst", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_res", res, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    begin
      int spurious;
      spurious = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (out_valid) spurious++;
      end
      chk("rstmid_no_spurious_valid", spurious, 0);
    end
    out_ready = 1'b0;
    accept(32'h1000_0000, 32'd28, 1'b0, 32'h0000_0001);
    collect("post_rst", 5);

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
